// File: rtl/pll_cram_reset_seq.sv
// PLL reset / lock-qualification sequencer that holds the 133 MHz CRAM logic in reset until refclk PLL lock is stable.
// Optional WAIT_LOCK timeout with sticky timeout_err is built only when PLL_CRAM_TIMEOUT_EN is defined.
module pll_cram_reset_seq #(
  parameter int unsigned RST_PULSE_CYCLES    = 16,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       soft_reset_req,
  output logic       pll_rst,
  output logic       core_reset,
  output logic       ready,
  output logic [7:0] relock_count,
  output logic       timeout_err
);

  localparam int unsigned MAX_A   = (RST_PULSE_CYCLES > LOCK_STABLE_CYCLES) ?
                                    RST_PULSE_CYCLES : LOCK_STABLE_CYCLES;
  localparam int unsigned MAX_CYC = (MAX_A > LOCK_TIMEOUT_CYCLES) ? MAX_A : LOCK_TIMEOUT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  typedef enum logic [1:0] {
    RESET_PLL = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } state_t;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic               lock_meta, locked_s;
  logic               lock_loss;
`ifdef PLL_CRAM_TIMEOUT_EN
  logic               tmo_hit;
`endif

  // pll_locked is asynchronous to refclk
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      lock_meta <= 1'b0;
      locked_s  <= 1'b0;
    end else begin
      lock_meta <= pll_locked;
      locked_s  <= lock_meta;
    end
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state <= RESET_PLL;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    lock_loss = 1'b0;
`ifdef PLL_CRAM_TIMEOUT_EN
    tmo_hit   = 1'b0;
`endif
    case (state)
      RESET_PLL: begin
        if (cnt == CNT_W'(RST_PULSE_CYCLES - 1)) begin
          state_nx = WAIT_LOCK;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      WAIT_LOCK: begin
        if (locked_s) begin
          state_nx = STABLE;
          cnt_nx   = '0;
        end
`ifdef PLL_CRAM_TIMEOUT_EN
        else if (cnt == CNT_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
          state_nx = RESET_PLL;
          cnt_nx   = '0;
          tmo_hit  = 1'b1;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
`endif
      end
      STABLE: begin
        if (!locked_s) begin
          state_nx = WAIT_LOCK;
          cnt_nx   = '0;
        end else if (cnt == CNT_W'(LOCK_STABLE_CYCLES - 1)) begin
          state_nx = RUN;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      RUN: begin
        if (!locked_s) begin
          state_nx  = RESET_PLL;
          cnt_nx    = '0;
          lock_loss = 1'b1;
        end
      end
      default: begin
        state_nx = RESET_PLL;
        cnt_nx   = '0;
      end
    endcase
    // Soft request restarts the sequence; a coincident lock loss is still counted above
    if (soft_reset_req) begin
      state_nx = RESET_PLL;
      cnt_nx   = '0;
    end
  end

  // Outputs decoded from next state so they switch on the same edge as the state
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      pll_rst      <= 1'b1;
      core_reset   <= 1'b1;
      ready        <= 1'b0;
      relock_count <= 8'd0;
    end else begin
      pll_rst    <= (state_nx == RESET_PLL);
      core_reset <= (state_nx != RUN);
      ready      <= (state_nx == RUN);
      if (lock_loss && (relock_count != 8'hFF))
        relock_count <= relock_count + 8'd1;
    end
  end

`ifdef PLL_CRAM_TIMEOUT_EN
  always_ff @(posedge refclk or posedge rst) begin
    if (rst)          timeout_err <= 1'b0;
    else if (tmo_hit) timeout_err <= 1'b1;
  end
`else
  assign timeout_err = 1'b0;
`endif

endmodule
